// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the auto-baud controller and its host.
interface uart_autobaud_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [7:0] divisor;
  logic       div_update;

  modport master (
    output start, abort,
    input  busy, done, error, err_code, divisor, div_update
  );

  modport slave (
    input  start, abort,
    output busy, done, error, err_code, divisor, div_update
  );
endinterface

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times the edges of a 0x55 sync character on rx_in and
// derives an 8-bit 16x-oversampling divisor, kept unchanged on any failure.
module uart_autobaud #(
  parameter int         CNT_WIDTH   = 16,
  parameter int         MIN_BIT     = 16,
  parameter logic [7:0] DEFAULT_DIV = 8'd4
) (
  input  logic uart_clk,
  input  logic rst_n,
  input  logic rx_in,
  uart_autobaud_if.slave bus
);
  localparam int TW = CNT_WIDTH + 3;

  typedef enum logic [2:0] {IDLE, WAIT_HIGH, WAIT_FALL, MEASURE, CALC} state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_q;
  logic [CNT_WIDTH-1:0] seg_cnt, w;
  logic [TW-1:0]        total;
  logic [3:0]           seg_idx;
  logic                 busy, done, error, div_update;
  logic [1:0]           err_code;
  logic [7:0]           divisor;

  // Every edge goes through the same flops, so segment widths are exact.
  logic rx_edge, rx_fall;
  assign rx_edge = rx_s ^ rx_q;
  assign rx_fall = rx_q & ~rx_s;

  // Bit-width tolerance window of +/- W/4 around the start-bit width.
  logic [CNT_WIDTH-1:0] tol_lo;
  logic [CNT_WIDTH:0]   tol_hi;
  logic                 in_tol;
  assign tol_lo = w - (w >> 2);
  assign tol_hi = {1'b0, w} + {1'b0, (w >> 2)};
  assign in_tol = (seg_cnt >= tol_lo) && ({1'b0, seg_cnt} <= tol_hi);

  logic [TW-1:0] div_calc;
  logic          div_bad;
  assign div_calc = (total + TW'(64)) >> 7;
  assign div_bad  = (div_calc == '0) || (div_calc > TW'(255));

  logic       seg_fail;
  logic [1:0] seg_code;
  always_comb begin
    seg_fail = 1'b0;
    seg_code = 2'd0;
    if (seg_idx == 4'd1) begin
      if (seg_cnt < CNT_WIDTH'(MIN_BIT)) begin
        seg_fail = 1'b1;
        seg_code = 2'd2;
      end
    end else if (!in_tol) begin
      seg_fail = 1'b1;
      seg_code = 2'd1;
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      state      <= IDLE;
      seg_cnt    <= '0;
      w          <= '0;
      total      <= '0;
      seg_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      div_update <= 1'b0;
      err_code   <= 2'd0;
      divisor    <= DEFAULT_DIV;
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      rx_q       <= rx_s;
      done       <= 1'b0;
      error      <= 1'b0;
      div_update <= 1'b0;
      if (bus.abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            state <= WAIT_HIGH;
            busy  <= 1'b1;
          end
          WAIT_HIGH: if (rx_s) state <= WAIT_FALL;
          WAIT_FALL: if (rx_fall) begin
            state   <= MEASURE;
            seg_cnt <= CNT_WIDTH'(1);
            total   <= '0;
            seg_idx <= 4'd1;
          end
          MEASURE: begin
            seg_cnt <= seg_cnt + CNT_WIDTH'(1);
            // Saturated counter means the line stopped toggling.
            if (seg_cnt == '1) begin
              state    <= IDLE;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd3;
            end else if (rx_edge) begin
              seg_cnt <= CNT_WIDTH'(1);
              if (seg_idx == 4'd1) w <= seg_cnt;
              if (seg_fail) begin
                state    <= IDLE;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= seg_code;
              end else begin
                if (seg_idx <= 4'd8) total <= total + TW'(seg_cnt);
                if (seg_idx == 4'd9) state <= CALC;
                else seg_idx <= seg_idx + 4'd1;
              end
            end
          end
          CALC: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (div_bad) begin
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              divisor    <= div_calc[7:0];
              done       <= 1'b1;
              div_update <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.err_code   = err_code;
  assign bus.divisor    = divisor;
  assign bus.div_update = div_update;
endmodule

// File: tb/tb_uart_autobaud.sv
// Directed + randomized bench for uart_autobaud; expectations come from a
// segment-list model of the sync-character rules.
module tb_uart_autobaud;
  typedef int seg_t [9];

  logic uart_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic rx_in    = 1'b1;
  logic rx_t     = 1'b1;

  always #5 uart_clk = ~uart_clk;

  uart_autobaud_if ifc ();
  uart_autobaud_if ift ();

  uart_autobaud dut (.uart_clk(uart_clk), .rst_n(rst_n), .rx_in(rx_in), .bus(ifc));
  // Narrow counter so the saturation timeout is reachable quickly.
  uart_autobaud #(.CNT_WIDTH(10)) dut_t (.uart_clk(uart_clk), .rst_n(rst_n), .rx_in(rx_t), .bus(ift));

  int checks = 0;
  int errors = 0;
  int n_done, n_err;
  logic [1:0] ev_code;
  logic [7:0] ev_div;
  int exp_div = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge uart_clk) begin
    if (rst_n && (ifc.done || ifc.error || ifc.div_update)) begin
      chk("upd_with_done", 32'(ifc.div_update), 32'(ifc.done));
      chk("done_and_error", 32'(ifc.done & ifc.error), 32'd0);
      if (ifc.done) begin
        n_done++;
        ev_div = ifc.divisor;
        chk("busy_at_done", 32'(ifc.busy), 32'd0);
      end
      if (ifc.error) begin
        n_err++;
        ev_code = ifc.err_code;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  // Reference: walk the segment list with the sync-character rules.
  function automatic void model(input seg_t s, output int code, output int dv);
    int w, total;
    code = 0; dv = 0;
    w = s[0];
    if (w < 16) begin code = 2; return; end
    total = w;
    for (int k = 1; k < 9; k++) begin
      if (s[k] < w - w / 4 || s[k] > w + w / 4) begin code = 1; return; end
      if (k < 8) total += s[k];
    end
    dv = (total + 64) / 128;
    if (dv == 0 || dv > 255) code = 2;
  endfunction

  function automatic seg_t uni(input int w);
    seg_t s;
    foreach (s[k]) s[k] = w;
    return s;
  endfunction

  task automatic arm();
    ifc.start = 1'b1; tick(1);
    ifc.start = 1'b0; tick(3);
  endtask

  task automatic send(input seg_t s, input bit mid_start);
    for (int i = 0; i < 9; i++) begin
      rx_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (mid_start && i == 3) begin
        ifc.start = 1'b1; tick(1);
        ifc.start = 1'b0; tick(s[i] - 1);
      end else begin
        tick(s[i]);
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic run(input string tag, input seg_t s, input bit mid_start);
    int code, dv;
    n_done = 0; n_err = 0;
    arm();
    send(s, mid_start);
    model(s, code, dv);
    tick(10);
    if (code == 0) begin
      chk({tag, "_ndone"}, n_done, 1);
      chk({tag, "_nerr"}, n_err, 0);
      chk({tag, "_evdiv"}, 32'(ev_div), dv);
      exp_div = dv;
    end else begin
      chk({tag, "_nerr"}, n_err, 1);
      chk({tag, "_ndone"}, n_done, 0);
      chk({tag, "_code"}, 32'(ev_code), code);
    end
    chk({tag, "_div"}, 32'(ifc.divisor), exp_div);
    chk({tag, "_busy"}, 32'(ifc.busy), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(ifc.busy), 0);
    chk({tag, "_done"}, 32'(ifc.done), 0);
    chk({tag, "_error"}, 32'(ifc.error), 0);
    chk({tag, "_upd"}, 32'(ifc.div_update), 0);
    chk({tag, "_code"}, 32'(ifc.err_code), 0);
    chk({tag, "_div"}, 32'(ifc.divisor), 4);
  endtask

  initial begin
    seg_t s;
    int lat, w, j;
    ifc.start = 1'b0; ifc.abort = 1'b0;
    ift.start = 1'b0; ift.abort = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick(3);

    run("b115200", uni(64), 1'b0);
    run("b9600", uni(768), 1'b0);
    run("b57600", uni(128), 1'b0);
    s = uni(64); s[2] = 90;  run("seg3_90", s, 1'b0);
    s = uni(64); s[3] = 72;  run("seg4_72", s, 1'b0);
    s = uni(64); s[5] = 47;  run("tol_lo_out", s, 1'b0);
    s = uni(64); s[6] = 81;  run("tol_hi_out", s, 1'b0);
    s = uni(64); s[1] = 48; s[2] = 80; run("tol_edges", s, 1'b0);
    run("div_range", uni(4200), 1'b0);
    run("busy_start", uni(96), 1'b1);

    // Start bit too short: reported right after the first rising edge.
    n_done = 0; n_err = 0;
    arm();
    rx_in = 1'b0; tick(10);
    rx_in = 1'b1; tick(6);
    chk("short_nerr", n_err, 1);
    chk("short_code", 32'(ev_code), 2);
    chk("short_div", 32'(ifc.divisor), exp_div);

    // Abort mid-measurement, then abort together with start.
    n_done = 0; n_err = 0;
    arm();
    rx_in = 1'b0; tick(64);
    rx_in = 1'b1; tick(64);
    rx_in = 1'b0; tick(30);
    ifc.abort = 1'b1; tick(1);
    ifc.abort = 1'b0;
    chk("abort_busy", 32'(ifc.busy), 0);
    tick(34);
    for (int i = 3; i < 9; i++) begin
      rx_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(64);
    end
    rx_in = 1'b1; tick(10);
    chk("abort_ndone", n_done, 0);
    chk("abort_nerr", n_err, 0);
    ifc.start = 1'b1; ifc.abort = 1'b1; tick(1);
    ifc.start = 1'b0; ifc.abort = 1'b0;
    chk("start_abort_busy0", 32'(ifc.busy), 0);
    tick(2);
    chk("start_abort_busy1", 32'(ifc.busy), 0);

    for (int r = 0; r < 6; r++) begin
      w = int'($urandom_range(150, 12));
      j = (w * 35) / 100;
      s[0] = w;
      for (int k = 1; k < 9; k++)
        s[k] = w + int'($urandom_range(2 * j)) - j;
      if (r % 2 == 0)
        for (int k = 1; k < 9; k++) s[k] = w + int'($urandom_range(w / 5)) - w / 10;
      run($sformatf("rand%0d", r), s, 1'b0);
    end

    // Timeout on the narrow-counter instance: line held low forever.
    ift.start = 1'b1; tick(1);
    ift.start = 1'b0; tick(3);
    chk("to_busy", 32'(ift.busy), 1);
    rx_t = 1'b0;
    lat = 0;
    while (!ift.error && lat < 1200) begin
      tick(1);
      lat++;
    end
    chk("to_seen", 32'(lat < 1200), 1);
    chk("to_lat", 32'(lat >= 1023 && lat <= 1030), 1);
    chk("to_code", 32'(ift.err_code), 3);
    chk("to_div", 32'(ift.divisor), 4);
    rx_t = 1'b1;
    tick(3);

    // Reset in segment 5 restores every output, including the divisor.
    run("pre_rst", uni(128), 1'b0);
    arm();
    for (int i = 0; i < 4; i++) begin
      rx_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(64);
    end
    rx_in = 1'b0; tick(20);
    rst_n = 1'b0; tick(1);
    chk_reset_vals("midrst");
    rx_in = 1'b1;
    rst_n = 1'b1;
    exp_div = 4;
    tick(3);
    run("post_rst", uni(768), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
